// File: rtl/cvxif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cvxif_pkg : shared constants for the CV-X-IF convolution datapath    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package cvxif_pkg;

  // Systolic-array front end: one 3x3 window of signed int8 elements
  localparam int SA_LANES  = 9;
  localparam int SA_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/skew_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | skew_lane : DEPTH-stage data+valid shift register, bubbles zeroed    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module skew_lane #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid
);

  logic signed [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]         r_valid;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_data[s] <= '0;
      end
      r_valid <= '0;
    end else if (i_clear) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_data[s] <= '0;
      end
      r_valid <= '0;
    end else begin
      // Invalid cycles enter as zero so downstream MACs see a neutral operand
      r_data[0]  <= i_valid ? i_data : '0;
      r_valid[0] <= i_valid;
      for (int s = 1; s < DEPTH; s++) begin
        r_data[s]  <= r_data[s-1];
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_valid[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sa_input_skew.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_input_skew : diagonal skew buffer (lane k delayed k extra cycles) |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module sa_input_skew
  import cvxif_pkg::*;
#(
  parameter int LANES  = SA_LANES,
  parameter int DATA_W = SA_DATA_W
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic signed [LANES*DATA_W-1:0] in_vec,
  input  logic                           i_clear,
  output logic signed [LANES*DATA_W-1:0] out_vec,
  output logic [LANES-1:0]               out_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] c_drain_load = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Drain counter spans the extra LANES-1 cycles the deepest lane needs
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (i_clear) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_STREAM: begin
          if (in_valid) begin
            if (in_last) begin
              w_state_next = S_DRAIN;
              w_cnt_next   = c_drain_load;
            end else begin
              w_state_next = S_STREAM;
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            w_state_next = S_IDLE;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DRAIN) && (r_cnt == '0);
    // Vectors issued while draining are dropped; lanes load a bubble instead
    w_accept = in_valid && (r_state != S_DRAIN);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_lane #(
      .DEPTH  (k + 1),
      .DATA_W (DATA_W)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_clear (i_clear),
      .i_valid (w_accept),
      .i_data  (in_vec[k*DATA_W +: DATA_W]),
      .o_data  (out_vec[k*DATA_W +: DATA_W]),
      .o_valid (out_valid[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_input_skew.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sa_input_skew : directed bench with cycle-indexed reference model |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_sa_input_skew;

  localparam int LANES = 9;
  localparam int DW    = 8;
  localparam int VW    = LANES * DW;
  localparam int NMAX  = 1024;

  logic             clk = 1'b0;
  logic             i_rstn, in_valid, in_last, i_clear;
  logic [VW-1:0]    in_vec;
  logic [VW-1:0]    out_vec;
  logic [LANES-1:0] out_valid;
  logic             busy, done;

  always #5 clk = ~clk;

  sa_input_skew #(.LANES(LANES), .DATA_W(DW)) dut (
    .i_clk     (clk),
    .i_rstn    (i_rstn),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_vec    (in_vec),
    .i_clear   (i_clear),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  int errors = 0;
  int checks = 0;

  // Model: what was accepted at each edge, the edge of the last accepted
  // in_last, the last flushing edge, and whether a stream is open.
  int      n      = 0;
  int      last_e = -1000;
  int      flush  = -1;
  bit      open_s = 1'b0;
  logic [DW-1:0] acc_d [NMAX][LANES];
  bit            acc_ok [NMAX];

  logic [VW-1:0]    cap_vec   [NMAX];
  logic [LANES-1:0] cap_valid [NMAX];
  bit               cap_busy  [NMAX];
  bit               cap_done  [NMAX];

  task automatic cmp(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, n, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input int base, input int mul);
    logic [VW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'(base + mul * k);
    return v;
  endfunction

  function automatic logic [DW-1:0] lane(input int e, input int k);
    logic [VW-1:0] v;
    v = cap_vec[e];
    return v[k*DW +: DW];
  endfunction

  task automatic check_model();
    logic [VW-1:0]    ev;
    logic [LANES-1:0] evld;
    int idx;
    bit ok;
    ev   = '0;
    evld = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = n - k;
      ok  = (idx > flush) && (idx >= 1) && acc_ok[idx];
      if (ok) begin
        ev[k*DW +: DW] = acc_d[idx][k];
        evld[k]        = 1'b1;
      end
    end
    cmp("out_vec", out_vec, ev);
    cmp("out_valid", VW'(out_valid), VW'(evld));
    cmp("busy", VW'(busy), VW'(open_s || (n >= last_e && n <= last_e + LANES - 1)));
    cmp("done", VW'(done), VW'(n == last_e + LANES - 1));
  endtask

  task automatic step(input bit v, input bit l, input logic [VW-1:0] vec,
                      input bit clr, input bit rstn);
    bit clr_like, acc;
    in_valid = v;
    in_last  = l;
    in_vec   = vec;
    i_clear  = clr;
    i_rstn   = rstn;
    @(posedge clk);
    n++;
    clr_like = clr || !rstn;
    acc = v && !clr_like && !(n >= last_e + 1 && n <= last_e + LANES);
    acc_ok[n] = acc;
    for (int k = 0; k < LANES; k++) acc_d[n][k] = vec[k*DW +: DW];
    if (clr_like) begin
      open_s = 1'b0;
      last_e = -1000;
      flush  = n;
    end else if (acc && l) begin
      last_e = n;
      open_s = 1'b0;
    end else if (acc) begin
      open_s = 1'b1;
    end
    #1;
    check_model();
    cap_vec[n]   = out_vec;
    cap_valid[n] = out_valid;
    cap_busy[n]  = busy;
    cap_done[n]  = done;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int n0, s0, l3, nn, b0, c0, il, r0;
    bit seen;
    logic [VW-1:0] tmp;

    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cmp("reset_vec", out_vec, '0);
    cmp("reset_valid", VW'(out_valid), '0);
    cmp("reset_busy", VW'(busy), '0);
    cmp("reset_done", VW'(done), '0);
    idle(2);

    // Single vector {1..9}
    step(1'b1, 1'b1, mkvec(1, 1), 1'b0, 1'b1);
    n0 = n;
    idle(12);
    cmp("single_busy_c1", VW'(cap_busy[n0]), VW'(1));
    cmp("single_l4", VW'(lane(n0 + 4, 4)), VW'(5));
    cmp("single_l8_early", VW'(lane(n0 + 7, 8)), VW'(0));
    cmp("single_l8", VW'(lane(n0 + 8, 8)), VW'(9));
    cmp("single_done_early", VW'(cap_done[n0 + 7]), VW'(0));
    cmp("single_done", VW'(cap_done[n0 + 8]), VW'(1));
    cmp("single_busy_end", VW'(cap_busy[n0 + 9]), VW'(0));

    // Back-to-back stream of 4, then a new stream right after done
    s0 = 0; l3 = 0;
    for (int v = 0; v < 4; v++) begin
      step(1'b1, (v == 3), mkvec(10 * v, 1), 1'b0, 1'b1);
      if (v == 0) s0 = n;
      if (v == 3) l3 = n;
    end
    idle(9);
    step(1'b1, 1'b1, mkvec(100, 1), 1'b0, 1'b1);
    nn = n;
    idle(12);
    cmp("b2b_l3_v2", VW'(lane(s0 + 5, 3)), VW'(23));
    cmp("b2b_done", VW'(cap_done[l3 + 8]), VW'(1));
    cmp("b2b_restart_busy", VW'(cap_busy[nn]), VW'(1));
    cmp("b2b_restart_l0", VW'(lane(nn, 0)), VW'(100));

    // Bubble with -128 in all lanes, garbage data on the invalid cycle
    step(1'b1, 1'b0, mkvec(-128, 0), 1'b0, 1'b1);
    b0 = n;
    step(1'b0, 1'b0, mkvec(77, 0), 1'b0, 1'b1);
    step(1'b1, 1'b1, mkvec(-128, 0), 1'b0, 1'b1);
    idle(12);
    cmp("bubble_l5_a", VW'(lane(b0 + 5, 5)), VW'(8'h80));
    cmp("bubble_l5_gap", VW'(lane(b0 + 6, 5)), VW'(0));
    tmp = VW'(cap_valid[b0 + 6]);
    cmp("bubble_l5_gap_valid", VW'(tmp[5]), VW'(0));
    cmp("bubble_l5_b", VW'(lane(b0 + 7, 5)), VW'(8'h80));

    // Clear three cycles into a stream, concurrent with in_valid
    for (int v = 0; v < 3; v++) step(1'b1, 1'b0, mkvec(30 + v, 1), 1'b0, 1'b1);
    step(1'b1, 1'b0, mkvec(40, 1), 1'b1, 1'b1);
    c0 = n;
    idle(12);
    cmp("clear_vec", cap_vec[c0], '0);
    cmp("clear_valid", VW'(cap_valid[c0]), VW'(0));
    cmp("clear_busy", VW'(cap_busy[c0]), VW'(0));
    seen = 1'b0;
    for (int e = c0; e <= n; e++) seen |= cap_done[e];
    cmp("clear_no_done", VW'(seen), VW'(0));

    // Illegal issue during drain and during the done cycle
    step(1'b1, 1'b1, mkvec(60, 1), 1'b0, 1'b1);
    il = n;
    idle(3);
    step(1'b1, 1'b0, mkvec(85, 0), 1'b0, 1'b1);
    idle(4);
    step(1'b1, 1'b0, mkvec(85, 0), 1'b0, 1'b1);
    idle(12);
    cmp("illegal_done", VW'(cap_done[il + 8]), VW'(1));
    cmp("illegal_idle_after", VW'(cap_busy[il + 9]), VW'(0));
    seen = 1'b0;
    for (int e = il; e <= n; e++)
      for (int k = 0; k < LANES; k++) seen |= (lane(e, k) == 8'd85);
    cmp("illegal_never_seen", VW'(seen), VW'(0));

    // Asynchronous reset during drain
    step(1'b1, 1'b1, mkvec(-5, -1), 1'b0, 1'b1);
    r0 = n;
    idle(3);
    i_rstn = 1'b0;
    #1;
    cmp("async_rst_vec", out_vec, '0);
    cmp("async_rst_valid", VW'(out_valid), '0);
    cmp("async_rst_busy", VW'(busy), '0);
    cmp("async_rst_done", VW'(done), '0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(12);
    seen = 1'b0;
    for (int e = r0; e <= n; e++) seen |= cap_done[e];
    cmp("rst_no_done", VW'(seen), VW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
